pulse_recover: RTL and testbench

- Receive side of the stretched-timestamp link. Takes a long, possibly asynchronous level pulse (nominally 4000 clk_main cycles wide) and recovers exactly one single-cycle event strobe in the clk_main domain.
- Includes a synchronizer, minimum-width qualification, stuck-high detection, re-arm hysteresis and a saturating event counter.
- Sits at the destination of timestamp lines inside the LandscapeSampling datapath.

---
 rtl/pulse_recover.sv | 171 +++++++++++++++++
 tb/tb_pulse_recover.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_recover.sv
// rtl/pulse_recover.sv - recovers one strobe per stretched timestamp pulse
// Synchronizes tstamp_in, qualifies pulse width, flags glitches and stuck lines, counts events.
module pulse_recover #(
  parameter int sync_stages = 2,
  parameter int min_hi      = 2000,
  parameter int max_hi      = 8000,
  parameter int min_lo      = 4,
  parameter int cnt_w       = 16,
  parameter int hw          = $clog2(max_hi + 1)
) (
  input  logic             clk_main,
  input  logic             clr,
  input  logic             tstamp_in,
  input  logic             cnt_clr,
  output logic             strobe,
  output logic             glitch,
  output logic             stuck,
  output logic             busy,
  output logic [cnt_w-1:0] event_cnt
);

  localparam int lw = $clog2(min_lo + 1);

  localparam logic [hw-1:0] W_QUAL  = hw'(min_hi - 1);
  localparam logic [hw-1:0] W_STUCK = hw'(max_hi - 1);
  localparam logic [hw-1:0] W_MAX   = hw'(max_hi);
  localparam logic [lw-1:0] L_DONE  = lw'(min_lo - 1);
  localparam logic [lw-1:0] L_ONE   = lw'(1);
  localparam logic [hw-1:0] W_ONE   = hw'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    QUAL  = 3'd1,
    HOLD  = 3'd2,
    STUCK = 3'd3,
    REARM = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [sync_stages-1:0] sync_q, sync_d;
  logic [hw-1:0]          wcnt_q, wcnt_d, wcnt_inc;
  logic [lw-1:0]          lcnt_q, lcnt_d;
  logic                   strobe_q, strobe_d;
  logic                   glitch_q, glitch_d;
  logic                   stuck_q, stuck_d;
  logic                   busy_q, busy_d;
  logic [cnt_w-1:0]       cnt_q, cnt_d;
  logic                   s;

  assign s = sync_q[sync_stages-1];

  always_comb begin
    sync_d   = {sync_q[sync_stages-2:0], tstamp_in};
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    lcnt_d   = lcnt_q;
    strobe_d = 1'b0;
    glitch_d = 1'b0;
    stuck_d  = stuck_q;
    // width counter saturates so a permanently stuck line cannot wrap it
    wcnt_inc = (wcnt_q >= W_MAX) ? W_MAX : wcnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = QUAL;
          wcnt_d  = W_ONE;
        end
      end
      QUAL: begin
        if (!s) begin
          glitch_d = 1'b1;
          state_d  = IDLE;
          wcnt_d   = '0;
        end else if (wcnt_q == W_QUAL) begin
          strobe_d = 1'b1;
          state_d  = HOLD;
          wcnt_d   = wcnt_inc;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end
      HOLD: begin
        if (s) begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc >= W_STUCK) begin
            state_d = STUCK;
            stuck_d = 1'b1;
          end
        end else begin
          state_d = REARM;
          lcnt_d  = L_ONE;
        end
      end
      STUCK: begin
        if (s) begin
          wcnt_d = wcnt_inc;
        end else begin
          stuck_d = 1'b0;
          state_d = REARM;
          lcnt_d  = L_ONE;
        end
      end
      REARM: begin
        // a short low gap is treated as part of the same event: no new strobe
        if (s) begin
          state_d = HOLD;
          wcnt_d  = wcnt_inc;
          if (wcnt_inc >= W_STUCK) begin
            state_d = STUCK;
            stuck_d = 1'b1;
          end
        end else if (lcnt_q >= L_DONE) begin
          state_d = IDLE;
          wcnt_d  = '0;
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
        lcnt_d  = '0;
        stuck_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);

    // counter follows the registered strobe, so cnt_clr in the strobe cycle leaves 1
    if (cnt_clr) begin
      cnt_d = cnt_w'(strobe_q);
    end else if (strobe_q && (cnt_q != {cnt_w{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_main or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      wcnt_q   <= '0;
      lcnt_q   <= '0;
      strobe_q <= 1'b0;
      glitch_q <= 1'b0;
      stuck_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      wcnt_q   <= wcnt_d;
      lcnt_q   <= lcnt_d;
      strobe_q <= strobe_d;
      glitch_q <= glitch_d;
      stuck_q  <= stuck_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign strobe    = strobe_q;
  assign glitch    = glitch_q;
  assign stuck     = stuck_q;
  assign busy      = busy_q;
  assign event_cnt = cnt_q;

endmodule

// File: tb/tb_pulse_recover.sv
// tb/tb_pulse_recover.sv - scoreboard bench for pulse_recover
// Stimulus queues expected strobe/glitch/stuck-rise events; a monitor pops and compares them.
module tb_pulse_recover;

  logic       clk_main = 1'b0;
  logic       clr;
  logic       tstamp_in;
  logic       cnt_clr;
  logic       strobe;
  logic       glitch;
  logic       stuck;
  logic       busy;
  logic [3:0] event_cnt;

  pulse_recover #(
    .sync_stages(2),
    .min_hi(8),
    .max_hi(20),
    .min_lo(3),
    .cnt_w(4)
  ) dut (
    .clk_main(clk_main),
    .clr(clr),
    .tstamp_in(tstamp_in),
    .cnt_clr(cnt_clr),
    .strobe(strobe),
    .glitch(glitch),
    .stuck(stuck),
    .busy(busy),
    .event_cnt(event_cnt)
  );

  always #5 clk_main = ~clk_main;

  int cyc = 0;
  always @(posedge clk_main) cyc++;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  localparam int K_STROBE = 1;
  localparam int K_GLITCH = 2;
  localparam int K_STUCK  = 3;

  ev_t q[$];
  int  n_cmp   = 0;
  int  n_fail  = 0;
  int  exp_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  bit stuck_prev  = 1'b0;
  bit cnt_pending = 1'b0;
  int cnt_want    = 0;

  task automatic take_ev(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_event_kind", kind, 0);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (kind == K_STROBE) begin
        cnt_pending = 1'b1;
        cnt_want    = e.cnt;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_main);
      if (cnt_pending) begin
        cnt_pending = 1'b0;
        chk("event_cnt_after_strobe", int'(event_cnt), cnt_want);
      end
      if (strobe) take_ev(K_STROBE);
      if (glitch) take_ev(K_GLITCH);
      if (stuck && !stuck_prev) take_ev(K_STUCK);
      stuck_prev = stuck;
    end
  end

  task automatic push(input int kind, input int at, input int cnt);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.cnt  = cnt;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk_main);
  endtask

  // Drive one pulse starting at a negedge; edge 0 is the next posedge.
  // Strobe shows after edge 9 (cyc base+10); glitch after edge width+2.
  task automatic pulse(input int width, input int gap, input int exp_kind,
                       input int stuck_at, input bit clr_at_strobe);
    int base;
    base = cyc;
    if (exp_kind == K_STROBE) begin
      if (clr_at_strobe) exp_cnt = 1;
      else if (exp_cnt < 15) exp_cnt++;
      push(K_STROBE, base + 10, exp_cnt);
    end else if (exp_kind == K_GLITCH) begin
      push(K_GLITCH, base + width + 3, exp_cnt);
    end
    if (stuck_at >= 0) push(K_STUCK, base + 1 + stuck_at, exp_cnt);
    for (int i = 0; i < width + gap; i++) begin
      tstamp_in = (i < width);
      cnt_clr   = clr_at_strobe && (i == 10);
      @(negedge clk_main);
    end
    tstamp_in = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    clr       = 1'b1;
    tstamp_in = 1'b0;
    cnt_clr   = 1'b0;
    repeat (2) @(negedge clk_main);
    chk("reset_strobe", int'(strobe), 0);
    chk("reset_glitch", int'(glitch), 0);
    chk("reset_stuck", int'(stuck), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_event_cnt", int'(event_cnt), 0);
    clr = 1'b0;
    repeat (3) @(negedge clk_main);

    // nominal 12-cycle pulse; busy drops three cycles after s falls
    base = cyc;
    pulse(12, 0, K_STROBE, -1, 1'b0);
    wait_cyc(base + 16);
    chk("nominal_busy_before_idle", int'(busy), 1);
    wait_cyc(base + 17);
    chk("nominal_busy_idle", int'(busy), 0);
    repeat (3) @(negedge clk_main);

    // width boundary
    pulse(7, 4, K_GLITCH, -1, 1'b0);
    pulse(8, 4, K_STROBE, -1, 1'b0);

    // stuck line, then a normal pulse after re-arm
    base = cyc;
    pulse(30, 0, K_STROBE, 20, 1'b0);
    wait_cyc(base + 32);
    chk("stuck_level_high", int'(stuck), 1);
    wait_cyc(base + 33);
    chk("stuck_level_low", int'(stuck), 0);
    wait_cyc(base + 36);
    pulse(10, 4, K_STROBE, -1, 1'b0);

    // short low gap keeps the event alive; the combined width reaches stuck
    pulse(10, 2, K_STROBE, -1, 1'b0);
    pulse(10, 4, 0, 10, 1'b0);
    pulse(10, 4, K_STROBE, -1, 1'b0);
    pulse(10, 4, K_STROBE, -1, 1'b0);

    // counter clear and saturation
    cnt_clr = 1'b1;
    @(negedge clk_main);
    cnt_clr = 1'b0;
    exp_cnt = 0;
    chk("cnt_clr_alone_a", int'(event_cnt), 0);
    for (int k = 0; k < 17; k++) pulse(8, 4, K_STROBE, -1, 1'b0);
    chk("cnt_saturated", int'(event_cnt), 15);
    pulse(10, 4, K_STROBE, -1, 1'b1);
    pulse(8, 4, K_STROBE, -1, 1'b0);
    chk("cnt_after_coincident_and_one", int'(event_cnt), 2);

    // reset mid-event while qualifying, tstamp held high through release
    tstamp_in = 1'b1;
    repeat (5) @(negedge clk_main);
    clr = 1'b1;
    #1;
    chk("midreset_strobe", int'(strobe), 0);
    chk("midreset_glitch", int'(glitch), 0);
    chk("midreset_stuck", int'(stuck), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_event_cnt", int'(event_cnt), 0);
    exp_cnt = 0;
    repeat (2) @(negedge clk_main);
    clr = 1'b0;
    exp_cnt = 1;
    push(K_STROBE, cyc + 10, exp_cnt);
    repeat (10) @(negedge clk_main);
    tstamp_in = 1'b0;
    repeat (8) @(negedge clk_main);
    chk("post_reset_cnt", int'(event_cnt), 1);

    cnt_clr = 1'b1;
    @(negedge clk_main);
    cnt_clr = 1'b0;
    chk("cnt_clr_alone_b", int'(event_cnt), 0);

    repeat (20) @(negedge clk_main);
    chk("events_outstanding", q.size(), 0);
    chk("final_busy", int'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
